sqwave_pattern_sequencer: RTL
=============================

// Module: sqwave_pattern_sequencer
// PURPOSE
//  Sequences a programmable square-wave pattern. A table of up to DEPTH steps holds (high, low, repeat) values.
//  On start, each step is played in order: HIGH for high cycles, then LOW for low cycles, for repeat+1 periods.
//  Step-to-step and period-to-period transitions have no gap cycles.
//  Sits between the register/config interface and the clock-output pins of the digital-clocks subsystem.
// PARAMETERS
//  DEPTH  8  number of pattern steps held (power of 2, >=2); AW = $clog2(DEPTH)
//  CW     4  width of high/low cycle counts
//  RW     4  width of per-step repeat count
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous, active-low reset
//  cfg_we     in   1      table write strobe; ignored while busy=1
//  cfg_addr   in   AW     table entry to write
//  cfg_high   in   CW     HIGH duration in cycles (0 treated as 1)
//  cfg_low    in   CW     LOW duration in cycles (0 treated as 1)
//  cfg_rep    in   RW     periods per step minus 1
//  num_steps  in   AW+1   steps to play, sampled at start; 0->1, >DEPTH clamps to DEPTH
//  start      in   1      begin playback; honoured only in IDLE
//  stop       in   1      synchronous abort; priority over everything except rst
//  wave_out   out  1      registered square wave
//  busy       out  1      1 while in HIGH or LOW state
//  done       out  1      one-cycle pulse after normal completion
//  step_idx   out  AW     index of the step currently playing
// BEHAVIOUR
//  Reset: state=IDLE; wave_out=0, busy=0, done=0, step_idx=0; counters=0.
//  Table contents are not cleared by reset and are undefined until written.
//  Table write: on an edge with cfg_we=1 and busy=0, entry cfg_addr <= {high, low, rep}.
//  States: IDLE, HIGH, LOW. wave_out=1 exactly when state==HIGH (registered).
//  IDLE, start=1, stop=0:
//   - Latch num_steps (clamped), load step 0 into cur_h/cur_l/cur_r, set cnt=0 and rep_cnt=0.
//   - Go to HIGH. wave_out and busy rise the cycle after start is sampled (latency 1).
//  HIGH: if cnt==cur_h-1 then cnt<=0, go to LOW; else cnt<=cnt+1. Holds for exactly max(H,1) cycles.
//  LOW: if cnt==cur_l-1 then end of period; else cnt<=cnt+1.
//  End of period, evaluated in order:
//   - rep_cnt<cur_r: rep_cnt++, go to HIGH.
//   - else if more steps remain: step_idx++, load next entry, rep_cnt=0, go to HIGH (no bubble).
//   - else: go to IDLE; done=1 for one cycle; busy=0.
//  stop=1 in any state: next edge state=IDLE, wave_out=0, busy=0, done=0, step_idx=0.
//  start while busy: ignored. start and stop together in IDLE: stop wins (stay IDLE).
//  Reset asserted mid-playback: immediate return to the reset values; the next start replays from step 0.
//  Counter compares use CW-bit arithmetic. Maximum all-ones values give 2^CW-1 cycles; no wrap past that.
//  The effective duration (0->1) is computed when a step loads.
// CONFIGURATION
//  SQSEQ_LOOP_EN defined:
//   - Adds input port loop (1 bit).
//   - When loop=1 at the end of the last step: wrap to step 0 with no gap. done is not pulsed; only stop ends playback.
//   - When loop=0: single pass as above.
//  SQSEQ_LOOP_EN undefined: no loop port; playback is always a single pass.
// TESTING
//  1. Reset: rst=0 mid-HIGH -> wave_out, busy, done, step_idx all 0 immediately; start after release replays step 0.
//  2. Step0 H=3 L=2 rep=1, num_steps=1, start:
//     - wave_out from cycle+1 reads 1,1,1,0,0,1,1,1,0,0.
//     - done=1 on the next cycle with busy=0.
//  3. Step0 H=0 L=0 rep=0, step1 H=2 L=1 rep=0, num_steps=2 -> wave_out 1,0,1,1,0; step_idx 0,0,1,1,1; no gap.
//  4. stop asserted on the 2nd HIGH cycle of H=5 -> next cycle wave_out=0, busy=0; done never pulses.
//  5. While busy: start=1 and cfg_we to step 0 with H=7 -> run unaffected. The next run still plays the old step 0 value.
//  6. SQSEQ_LOOP_EN, loop=1, 2 steps H=1 L=1 -> continuous 1,0,1,0; step_idx 0,0,1,1,0,...; done stays 0 until stop.

Source files
------------

// File: rtl/sqwave_pattern_sequencer.sv
// sqwave_pattern_sequencer
// Plays a table of (high, low, repeat) square-wave steps back to back with no
// gap cycles between periods or steps. Each step produces repeat+1 periods of
// HIGH for max(high,1) cycles followed by LOW for max(low,1) cycles.
// Optional feature: define SQSEQ_LOOP_EN to add the `loop` input, which wraps
// playback from the last step back to step 0 instead of finishing.
// The pattern table is plain storage: it is not cleared by reset and may only
// be written while the sequencer is idle.
module sqwave_pattern_sequencer #(
  parameter int DEPTH = 8,
  parameter int CW    = 4,
  parameter int RW    = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_low,
  input  logic [RW-1:0] cfg_rep,
  input  logic [AW:0]   num_steps,
  input  logic          start,
  input  logic          stop,
`ifdef SQSEQ_LOOP_EN
  input  logic          loop,
`endif
  output logic          wave_out,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step_idx
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // A programmed duration of 0 behaves as 1 cycle.
  function automatic logic [CW-1:0] eff_dur(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  // Requested step count: 0 plays one step, anything above DEPTH plays DEPTH.
  function automatic logic [AW:0] clamp_steps(input logic [AW:0] n);
    if (n == '0)
      return (AW+1)'(1);
    if (n > DEPTH_N)
      return DEPTH_N;
    return n;
  endfunction

  // Pattern table
  logic [CW-1:0] r_tab_h [DEPTH];
  logic [CW-1:0] r_tab_l [DEPTH];
  logic [RW-1:0] r_tab_r [DEPTH];

  // Active step, already converted to effective durations
  logic [CW-1:0] r_cur_h;
  logic [CW-1:0] r_cur_l;
  logic [RW-1:0] r_cur_r;

  // Control state
  state_t        r_state;
  state_t        w_nstate;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_ncnt;
  logic [RW-1:0] r_rep;
  logic [RW-1:0] w_nrep;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_nidx;
  logic [AW:0]   r_nsteps;
  logic [AW:0]   w_nsteps;
  logic          r_wave;
  logic          r_busy;
  logic          r_done;
  logic          w_ndone;

  // Step-load request toward the datapath
  logic          w_load;
  logic [AW-1:0] w_load_addr;

  // Decoded conditions
  logic          w_hend;
  logic          w_lend;
  logic          w_more_reps;
  logic          w_last_step;
  logic          w_loop;
  logic          w_tab_we;

`ifdef SQSEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_hend      = (r_cnt == (r_cur_h - CW'(1)));
  assign w_lend      = (r_cnt == (r_cur_l - CW'(1)));
  assign w_more_reps = (r_rep < r_cur_r);
  assign w_last_step = ({1'b0, r_idx} == (r_nsteps - (AW+1)'(1)));
  assign w_tab_we    = cfg_we && !r_busy;

  // Next-state and next-control logic; stop overrides every other transition
  always_comb begin
    w_nstate    = r_state;
    w_ncnt      = r_cnt;
    w_nrep      = r_rep;
    w_nidx      = r_idx;
    w_nsteps    = r_nsteps;
    w_ndone     = 1'b0;
    w_load      = 1'b0;
    w_load_addr = '0;
    if (stop) begin
      w_nstate = S_IDLE;
      w_ncnt   = '0;
      w_nrep   = '0;
      w_nidx   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_nstate    = S_HIGH;
            w_nsteps    = clamp_steps(num_steps);
            w_load      = 1'b1;
            w_load_addr = '0;
            w_ncnt      = '0;
            w_nrep      = '0;
            w_nidx      = '0;
          end
        end
        S_HIGH: begin
          if (w_hend) begin
            w_ncnt   = '0;
            w_nstate = S_LOW;
          end else begin
            w_ncnt = r_cnt + CW'(1);
          end
        end
        S_LOW: begin
          if (!w_lend) begin
            w_ncnt = r_cnt + CW'(1);
          end else begin
            w_ncnt = '0;
            if (w_more_reps) begin
              // another period of the same step
              w_nrep   = r_rep + RW'(1);
              w_nstate = S_HIGH;
            end else if (!w_last_step) begin
              // next step starts on the very next cycle
              w_nidx      = r_idx + AW'(1);
              w_load      = 1'b1;
              w_load_addr = r_idx + AW'(1);
              w_nrep      = '0;
              w_nstate    = S_HIGH;
            end else if (w_loop) begin
              // wrap to the first step without a gap and without done
              w_nidx      = '0;
              w_load      = 1'b1;
              w_load_addr = '0;
              w_nrep      = '0;
              w_nstate    = S_HIGH;
            end else begin
              w_nstate = S_IDLE;
              w_ndone  = 1'b1;
            end
          end
        end
        default: begin
          w_nstate = S_IDLE;
          w_ncnt   = '0;
          w_nrep   = '0;
          w_nidx   = '0;
        end
      endcase
    end
  end

  // State register and registered outputs, cleared asynchronously by rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rep    <= '0;
      r_idx    <= '0;
      r_nsteps <= '0;
      r_wave   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_rep    <= w_nrep;
      r_idx    <= w_nidx;
      r_nsteps <= w_nsteps;
      r_wave   <= (w_nstate == S_HIGH);
      r_busy   <= (w_nstate != S_IDLE);
      r_done   <= w_ndone;
    end
  end

  // Table writes (idle only) and step loads; no reset on this storage
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_cur_h <= eff_dur(r_tab_h[w_load_addr]);
      r_cur_l <= eff_dur(r_tab_l[w_load_addr]);
      r_cur_r <= r_tab_r[w_load_addr];
    end
    if (w_tab_we) begin
      r_tab_h[cfg_addr] <= cfg_high;
      r_tab_l[cfg_addr] <= cfg_low;
      r_tab_r[cfg_addr] <= cfg_rep;
    end
  end

  assign wave_out = r_wave;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_idx;

endmodule
